idu_pipe: RTL and testbench

IDU_PIPE -- requirements
Module: idu_pipe

---
 rtl/idu_pipe_if.sv | 52 +++++
 rtl/idu_pipe.sv | 233 +++++++++++++++++++++++
 tb/tb_idu_pipe.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idu_pipe_if.sv
// idu_pipe_if: handshake/bus bundle for the decode stage.
// slave = decode stage side, master = fetch/execute/retire side.
interface idu_pipe_if #(
  parameter int XLEN           = 32,
  parameter int XREG_ADDRWIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               instruction;
  logic [XLEN-1:0]           pc_in;
  logic                      flush;
  logic                      wb_en;
  logic [XREG_ADDRWIDTH-1:0] wb_rd;
  logic                      out_valid;
  logic                      out_ready;
  logic [6:0]                opcode;
  logic [2:0]                func3;
  logic [6:0]                func7;
  logic [XREG_ADDRWIDTH-1:0] dec_rs1;
  logic [XREG_ADDRWIDTH-1:0] dec_rs2;
  logic [XREG_ADDRWIDTH-1:0] dec_rd;
  logic                      rs1_en;
  logic                      rs2_en;
  logic                      rd_en;
  logic [2:0]                it_type;
  logic [XLEN-1:0]           imm_num;
  logic [XLEN-1:0]           pc_out;
  logic                      illegal;
  logic                      is_muldiv;

  modport slave (
    input  in_valid, instruction, pc_in, flush,
    input  wb_en, wb_rd, out_ready,
    output in_ready, out_valid,
    output opcode, func3, func7,
    output dec_rs1, dec_rs2, dec_rd,
    output rs1_en, rs2_en, rd_en,
    output it_type, imm_num, pc_out,
    output illegal, is_muldiv
  );

  modport master (
    output in_valid, instruction, pc_in, flush,
    output wb_en, wb_rd, out_ready,
    input  in_ready, out_valid,
    input  opcode, func3, func7,
    input  dec_rs1, dec_rs2, dec_rd,
    input  rs1_en, rs2_en, rd_en,
    input  it_type, imm_num, pc_out,
    input  illegal, is_muldiv
  );
endinterface

// File: rtl/idu_pipe.sv
// idu_pipe: RV32I decode stage, one output register, pending-bit
// scoreboard stalling RAW/WAW hazards.
// Ports: clk, rst (sync, active-high), io_bus (idu_pipe_if.slave):
//   in_valid/in_ready/instruction/pc_in upstream, flush, wb_en/wb_rd
//   retire, out_valid/out_ready + decoded bundle downstream.
// Macro IDU_MEXT_EN: decode M-extension (func7=0000001) as R-type.
module idu_pipe #(
  parameter int XLEN           = 32,
  parameter int XREG_ADDRWIDTH = 5
) (
  input logic      clk,
  input logic      rst,
  idu_pipe_if.slave io_bus
);
  localparam int NREG = 1 << XREG_ADDRWIDTH;

  typedef enum logic [2:0] {
    IT_R   = 3'd0,
    IT_I   = 3'd1,
    IT_S   = 3'd2,
    IT_B   = 3'd3,
    IT_U   = 3'd4,
    IT_J   = 3'd5,
    IT_ERR = 3'd7
  } it_e;

  logic [31:0]               w_ins;
  logic [6:0]                w_op;
  logic [6:0]                w_f7;
  logic [XREG_ADDRWIDTH-1:0] w_rs1;
  logic [XREG_ADDRWIDTH-1:0] w_rs2;
  logic [XREG_ADDRWIDTH-1:0] w_rd;
  it_e                       w_type;
  logic                      w_rs1_en;
  logic                      w_rs2_en;
  logic                      w_rd_en;
  logic [31:0]               w_imm32;
  logic [XLEN-1:0]           w_imm;
  logic                      w_hazard;
  logic                      w_in_ready;
  logic                      w_in_fire;
  logic [NREG-1:0]           w_pend_nxt;
`ifdef IDU_MEXT_EN
  logic                      w_muldiv;
  logic                      r_muldiv;
`endif

  logic                      r_valid;
  logic [NREG-1:0]           r_pend;
  logic [6:0]                r_opcode;
  logic [2:0]                r_func3;
  logic [6:0]                r_func7;
  logic [XREG_ADDRWIDTH-1:0] r_rs1;
  logic [XREG_ADDRWIDTH-1:0] r_rs2;
  logic [XREG_ADDRWIDTH-1:0] r_rd;
  logic                      r_rs1_en;
  logic                      r_rs2_en;
  logic                      r_rd_en;
  it_e                       r_type;
  logic [XLEN-1:0]           r_imm;
  logic [XLEN-1:0]           r_pc;
  logic                      r_illegal;

  assign w_ins = io_bus.instruction;
  assign w_op  = w_ins[6:0];
  assign w_f7  = w_ins[31:25];
  assign w_rs1 = XREG_ADDRWIDTH'(w_ins[19:15]);
  assign w_rs2 = XREG_ADDRWIDTH'(w_ins[24:20]);
  assign w_rd  = XREG_ADDRWIDTH'(w_ins[11:7]);

  // R-type is only legal for the known func7 values.
  always_comb begin
    w_type = IT_ERR;
`ifdef IDU_MEXT_EN
    w_muldiv = 1'b0;
`endif
    unique case (1'b1)
      (w_op == 7'b0110111),
      (w_op == 7'b0010111): w_type = IT_U;
      (w_op == 7'b1101111): w_type = IT_J;
      (w_op == 7'b1100111),
      (w_op == 7'b0000011),
      (w_op == 7'b0010011): w_type = IT_I;
      (w_op == 7'b0100011): w_type = IT_S;
      (w_op == 7'b1100011): w_type = IT_B;
      (w_op == 7'b0110011) &&
      ((w_f7 == 7'b0000000) ||
       (w_f7 == 7'b0100000)): w_type = IT_R;
`ifdef IDU_MEXT_EN
      (w_op == 7'b0110011) &&
      (w_f7 == 7'b0000001): begin
        w_type   = IT_R;
        w_muldiv = 1'b1;
      end
`endif
      default: w_type = IT_ERR;
    endcase
  end

  always_comb begin
    w_rs1_en = 1'b0;
    w_rs2_en = 1'b0;
    w_rd_en  = 1'b0;
    w_imm32  = '0;
    unique case (w_type)
      IT_R: begin
        w_rs1_en = 1'b1;
        w_rs2_en = 1'b1;
        w_rd_en  = 1'b1;
      end
      IT_I: begin
        w_rs1_en = 1'b1;
        w_rd_en  = 1'b1;
        w_imm32  = {{20{w_ins[31]}}, w_ins[31:20]};
      end
      IT_S: begin
        w_rs1_en = 1'b1;
        w_rs2_en = 1'b1;
        w_imm32  = {{20{w_ins[31]}}, w_ins[31:25],
                    w_ins[11:7]};
      end
      IT_B: begin
        w_rs1_en = 1'b1;
        w_rs2_en = 1'b1;
        w_imm32  = {{19{w_ins[31]}}, w_ins[31], w_ins[7],
                    w_ins[30:25], w_ins[11:8], 1'b0};
      end
      IT_U: begin
        w_rd_en = 1'b1;
        w_imm32 = {w_ins[31:12], 12'b0};
      end
      IT_J: begin
        w_rd_en = 1'b1;
        w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12],
                   w_ins[20], w_ins[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  // Scoreboard read uses the registered bits, so a same-cycle
  // retire of the blocking register still stalls this cycle.
  assign w_hazard = io_bus.in_valid &
                    ((w_rs1_en & r_pend[w_rs1]) |
                     (w_rs2_en & r_pend[w_rs2]) |
                     (w_rd_en  & r_pend[w_rd]));

  assign w_in_ready = (~r_valid | io_bus.out_ready) &
                      ~w_hazard & ~io_bus.flush & ~rst;
  assign w_in_fire  = io_bus.in_valid & w_in_ready;

  // Set is applied last so it wins over a same-entry clear.
  always_comb begin
    w_pend_nxt = r_pend;
    if (io_bus.wb_en)
      w_pend_nxt[io_bus.wb_rd] = 1'b0;
    if (io_bus.flush && r_valid && r_rd_en)
      w_pend_nxt[r_rd] = 1'b0;
    if (w_in_fire && w_rd_en)
      w_pend_nxt[w_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pend    <= '0;
      r_opcode  <= '0;
      r_func3   <= '0;
      r_func7   <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_rs1_en  <= 1'b0;
      r_rs2_en  <= 1'b0;
      r_rd_en   <= 1'b0;
      r_type    <= IT_R;
      r_imm     <= '0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
`ifdef IDU_MEXT_EN
      r_muldiv  <= 1'b0;
`endif
    end else begin
      r_pend <= w_pend_nxt;
      if (w_in_fire) begin
        r_valid   <= 1'b1;
        r_opcode  <= w_op;
        r_func3   <= w_ins[14:12];
        r_func7   <= w_f7;
        r_rs1     <= w_rs1;
        r_rs2     <= w_rs2;
        r_rd      <= w_rd;
        r_rs1_en  <= w_rs1_en;
        r_rs2_en  <= w_rs2_en;
        r_rd_en   <= w_rd_en;
        r_type    <= w_type;
        r_imm     <= w_imm;
        r_pc      <= io_bus.pc_in;
        r_illegal <= (w_type == IT_ERR);
`ifdef IDU_MEXT_EN
        r_muldiv  <= w_muldiv;
`endif
      end else if (io_bus.flush ||
                   (r_valid && io_bus.out_ready)) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_valid;
  assign io_bus.opcode    = r_opcode;
  assign io_bus.func3     = r_func3;
  assign io_bus.func7     = r_func7;
  assign io_bus.dec_rs1   = r_rs1;
  assign io_bus.dec_rs2   = r_rs2;
  assign io_bus.dec_rd    = r_rd;
  assign io_bus.rs1_en    = r_rs1_en;
  assign io_bus.rs2_en    = r_rs2_en;
  assign io_bus.rd_en     = r_rd_en;
  assign io_bus.it_type   = r_type;
  assign io_bus.imm_num   = r_imm;
  assign io_bus.pc_out    = r_pc;
  assign io_bus.illegal   = r_illegal;
`ifdef IDU_MEXT_EN
  assign io_bus.is_muldiv = r_muldiv;
`else
  assign io_bus.is_muldiv = 1'b0;
`endif
endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: directed self-checking bench for idu_pipe,
// XLEN=32 instance plus an XLEN=64 instance for wide immediates.
module tb_idu_pipe;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  idu_pipe_if #(.XLEN(32), .XREG_ADDRWIDTH(5)) bus ();
  idu_pipe_if #(.XLEN(64), .XREG_ADDRWIDTH(5)) bus64 ();

  idu_pipe #(.XLEN(32), .XREG_ADDRWIDTH(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  idu_pipe #(.XLEN(64), .XREG_ADDRWIDTH(5)) dut64 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // instr, type, imm, illegal, rs2_en, rd_en
  logic [31:0] tv_ins [5];
  logic [2:0]  tv_typ [5];
  logic [31:0] tv_imm [5];
  logic        tv_ill [5];
  logic        tv_rs2 [5];
  logic        tv_rd  [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tv_ins[0] = 32'hFFFFFFFF; tv_typ[0] = 3'd7;
    tv_imm[0] = 32'h0;        tv_ill[0] = 1'b1;
    tv_rs2[0] = 1'b0;         tv_rd[0]  = 1'b0;
    tv_ins[1] = 32'h042081B3; tv_typ[1] = 3'd7;
    tv_imm[1] = 32'h0;        tv_ill[1] = 1'b1;
    tv_rs2[1] = 1'b0;         tv_rd[1]  = 1'b0;
    tv_ins[2] = 32'hFE20AC23; tv_typ[2] = 3'd2;
    tv_imm[2] = 32'hFFFFFFF8; tv_ill[2] = 1'b0;
    tv_rs2[2] = 1'b1;         tv_rd[2]  = 1'b0;
    tv_ins[3] = 32'h0080006F; tv_typ[3] = 3'd5;
    tv_imm[3] = 32'h8;        tv_ill[3] = 1'b0;
    tv_rs2[3] = 1'b0;         tv_rd[3]  = 1'b1;
    tv_ins[4] = 32'h402081B3; tv_typ[4] = 3'd0;
    tv_imm[4] = 32'h0;        tv_ill[4] = 1'b0;
    tv_rs2[4] = 1'b1;         tv_rd[4]  = 1'b1;

    rst               = 1'b1;
    bus.in_valid      = 1'b1;
    bus.instruction   = 32'hFFF00093;
    bus.pc_in         = '0;
    bus.flush         = 1'b0;
    bus.wb_en         = 1'b0;
    bus.wb_rd         = '0;
    bus.out_ready     = 1'b1;
    bus64.in_valid    = 1'b0;
    bus64.instruction = '0;
    bus64.pc_in       = '0;
    bus64.flush       = 1'b0;
    bus64.wb_en       = 1'b0;
    bus64.wb_rd       = '0;
    bus64.out_ready   = 1'b1;

    tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_it_type", 64'(bus.it_type), 64'd0);
    check("rst_imm", 64'(bus.imm_num), 64'd0);
    check("rst_illegal", 64'(bus.illegal), 64'd0);

    // addi x1,x0,-1 at 0x100
    rst       = 1'b0;
    bus.pc_in = 32'h100;
    #1;
    check("addi_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check("addi_valid", 64'(bus.out_valid), 64'd1);
    check("addi_type", 64'(bus.it_type), 64'd1);
    check("addi_rd", 64'(bus.dec_rd), 64'd1);
    check("addi_rd_en", 64'(bus.rd_en), 64'd1);
    check("addi_rs2_en", 64'(bus.rs2_en), 64'd0);
    check("addi_imm", 64'(bus.imm_num), 64'hFFFFFFFF);
    check("addi_pc", 64'(bus.pc_out), 64'h100);
    check("addi_opcode", 64'(bus.opcode), 64'h13);

    // add x3,x1,x2 stalls on pending x1
    bus.instruction = 32'h002081B3;
    bus.pc_in       = 32'h104;
    #1;
    check("raw_stall", 64'(bus.in_ready), 64'd0);
    tick();
    check("raw_drain", 64'(bus.out_valid), 64'd0);
    bus.wb_en = 1'b1;
    bus.wb_rd = 5'd1;
    #1;
    check("raw_wb_same", 64'(bus.in_ready), 64'd0);
    tick();
    bus.wb_en = 1'b0;
    #1;
    check("raw_release", 64'(bus.in_ready), 64'd1);
    tick();
    check("add_valid", 64'(bus.out_valid), 64'd1);
    check("add_type", 64'(bus.it_type), 64'd0);
    check("add_rd", 64'(bus.dec_rd), 64'd3);
    check("add_rs2", 64'(bus.dec_rs2), 64'd2);
    check("add_rs2_en", 64'(bus.rs2_en), 64'd1);

    // backpressure 3 cycles, then back-to-back
    bus.wb_en       = 1'b1;
    bus.wb_rd       = 5'd3;
    bus.out_ready   = 1'b0;
    bus.instruction = 32'h00500213;
    bus.pc_in       = 32'h108;
    #1;
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.wb_en = 1'b0;
      #1;
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_rd", 64'(bus.dec_rd), 64'd3);
      check("bp_pc", 64'(bus.pc_out), 64'h104);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_resume", 64'(bus.in_ready), 64'd1);
    tick();
    check("b2b0_rd", 64'(bus.dec_rd), 64'd4);
    check("b2b0_imm", 64'(bus.imm_num), 64'd5);
    check("b2b0_pc", 64'(bus.pc_out), 64'h108);
    bus.instruction = 32'h00700313;
    bus.pc_in       = 32'h10C;
    #1;
    check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check("b2b1_valid", 64'(bus.out_valid), 64'd1);
    check("b2b1_rd", 64'(bus.dec_rd), 64'd6);
    check("b2b1_imm", 64'(bus.imm_num), 64'd7);
    check("b2b1_pc", 64'(bus.pc_out), 64'h10C);
    bus.in_valid = 1'b0;
    tick();
    check("b2b_drain", 64'(bus.out_valid), 64'd0);

    // lui x5 then flush
    bus.instruction = 32'h123452B7;
    bus.pc_in       = 32'h110;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("lui_valid", 64'(bus.out_valid), 64'd1);
    check("lui_type", 64'(bus.it_type), 64'd4);
    check("lui_imm", 64'(bus.imm_num), 64'h12345000);
    check("lui_rd", 64'(bus.dec_rd), 64'd5);
    bus.flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    bus.instruction = 32'h000283B3;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    #1;
    check("flush_pend5", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("flush_next_rd", 64'(bus.dec_rd), 64'd7);

    // mul x1,x2,x3
    bus.instruction = 32'h023100B3;
    bus.pc_in       = 32'h114;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
`ifdef IDU_MEXT_EN
    check("mul_muldiv", 64'(bus.is_muldiv), 64'd1);
    check("mul_illegal", 64'(bus.illegal), 64'd0);
    check("mul_type", 64'(bus.it_type), 64'd0);
    check("mul_rd_en", 64'(bus.rd_en), 64'd1);
`else
    check("mul_muldiv", 64'(bus.is_muldiv), 64'd0);
    check("mul_illegal", 64'(bus.illegal), 64'd1);
    check("mul_type", 64'(bus.it_type), 64'd7);
    check("mul_rd_en", 64'(bus.rd_en), 64'd0);
`endif
    bus.wb_en = 1'b1;
    bus.wb_rd = 5'd1;
    tick();
    bus.wb_en = 1'b0;

    for (int i = 0; i < 5; i++) begin
      bus.instruction = tv_ins[i];
      bus.in_valid    = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("tv_type", 64'(bus.it_type), 64'(tv_typ[i]));
      check("tv_imm", 64'(bus.imm_num), 64'(tv_imm[i]));
      check("tv_illegal", 64'(bus.illegal), 64'(tv_ill[i]));
      check("tv_rs2_en", 64'(bus.rs2_en), 64'(tv_rs2[i]));
      check("tv_rd_en", 64'(bus.rd_en), 64'(tv_rd[i]));
    end
    // the sub above set pending[3]; retire it
    bus.wb_en = 1'b1;
    bus.wb_rd = 5'd3;
    tick();
    bus.wb_en = 1'b0;

    // set and clear of x8 in one cycle: set wins
    bus.instruction = 32'h00100413;
    bus.in_valid    = 1'b1;
    bus.wb_en       = 1'b1;
    bus.wb_rd       = 5'd8;
    tick();
    bus.wb_en       = 1'b0;
    bus.instruction = 32'h000404B3;
    #1;
    check("setclr_stall", 64'(bus.in_ready), 64'd0);
    bus.wb_en = 1'b1;
    tick();
    bus.wb_en = 1'b0;
    #1;
    check("setclr_release", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("setclr_rd", 64'(bus.dec_rd), 64'd9);

    // reset while stalled discards the bundle and scoreboard
    bus.out_ready   = 1'b0;
    bus.instruction = 32'h00100513;
    bus.in_valid    = 1'b1;
    tick();
    check("rs_held", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rs_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    rst = 1'b0;
    check("rs_valid", 64'(bus.out_valid), 64'd0);
    check("rs_rd", 64'(bus.dec_rd), 64'd0);
    bus.instruction = 32'h000505B3;
    #1;
    check("rs_pend10", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;

    // XLEN=64: backward branch and negative lui
    bus64.instruction = 32'hFE000EE3;
    bus64.pc_in       = 64'h200;
    bus64.in_valid    = 1'b1;
    tick();
    check("w64_b_type", 64'(bus64.it_type), 64'd3);
    check("w64_b_imm", bus64.imm_num, 64'hFFFFFFFFFFFFFFFC);
    check("w64_b_illegal", 64'(bus64.illegal), 64'd0);
    check("w64_b_pc", bus64.pc_out, 64'h200);
    bus64.instruction = 32'h800002B7;
    tick();
    bus64.in_valid = 1'b0;
    check("w64_u_type", 64'(bus64.it_type), 64'd4);
    check("w64_u_imm", bus64.imm_num, 64'hFFFFFFFF80000000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
